// File: rtl/rv32_pkg.sv
// Shared RV32 constants and the fetch state type used by the fetch unit.
package rv32_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam int FETCH_ENTRY_W = 2 * XLEN;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Clear the byte-offset bits so every fetch is word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: shift-register FIFO whose head entry is itself the output
// register, so the head is visible the cycle after a push into an empty FIFO
// and stays put while it is not popped.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;
  logic [IDX_W-1:0] wr_idx;

  assign head_valid = (count != '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign head_data  = mem[0];
  assign do_pop     = pop && head_valid;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push    = push && (!full || do_pop);
  // Entries shift down on a pop, so the write slot moves down with them.
  assign wr_idx     = IDX_W'(do_pop ? count - CNT_W'(1) : count);

  // Occupancy tracking; flush empties the buffer regardless of push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (do_push && !do_pop) begin
      count <= count + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count <= count - CNT_W'(1);
    end
  end

  // Entry storage: shift toward the head on pop, then drop the new word in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!flush) begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem[i] <= mem[i+1];
        end
      end
      if (do_push) begin
        mem[wr_idx] <= push_data;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word fetch at a time, buffers returned
// words with their addresses, and discards responses made stale by a redirect.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  fetch_state_t                state;
  fetch_state_t                state_next;
  logic [XLEN-1:0]             fetch_pc;
  logic [XLEN-1:0]             req_pc;
  logic                        gnt_fire;
  logic                        fifo_push;
  logic                        fifo_full;
  logic [FETCH_ENTRY_W-1:0]    head_data;

  assign imem_addr = fetch_pc;
  assign gnt_fire  = imem_req && imem_gnt;

  // State register; reset abandons any request in flight by returning to RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state, request and push decisions.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    fifo_push  = 1'b0;
    case (state)
      RUN: begin
        // The reset term keeps the request low while the block is held in reset.
        imem_req = reset && !fifo_full && !redirect_valid;
        // A grant never coincides with a redirect because the request is
        // suppressed in the redirect cycle.
        if (gnt_fire) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          fifo_push  = !redirect_valid;
          state_next = RUN;
        end else if (redirect_valid) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Fetch address: redirect target takes priority over sequential advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= align_pc(redirect_pc);
    end else if (gnt_fire) begin
      fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
    end
  end

  // Address of the outstanding request, paired with its returning word.
  always_ff @(posedge clk) begin
    if (gnt_fire) begin
      req_pc <= fetch_pc;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (fifo_push),
    .push_data  ({req_pc, imem_rdata}),
    .pop        (instr_ready),
    .head_data  (head_data),
    .head_valid (instr_valid),
    .full       (fifo_full)
  );

  assign instr    = head_data[XLEN-1:0];
  assign instr_pc = head_data[FETCH_ENTRY_W-1:XLEN];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a memory model answers grants after a
// random latency, and a queue-based reference predicts every output cycle.
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: next fetch address, whether a fetch is in flight, and
  // the addresses of the words the decode side should see, oldest first.
  logic [31:0] m_pc;
  bit          m_out;
  logic [31:0] q[$];

  // Memory model state.
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  bit          mem_stale;
  int          lat_min = 1;
  int          lat_max = 1;

  bit          rst_hold;
  int          cyc = 0;
  logic [31:0] fire_log[$];
  int          first_fire_cyc;
  int          first_valid_cyc;
  int          redir_cyc;
  bit          saw_dead;
  bit          cap_pc;
  logic [31:0] cap_val;

  // Word stored at an address; low bits 01 so it can never equal 0xDEADBEEF.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2] ^ 30'h2AAA_AAAA, 2'b01};
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (fire_log.size() > i) ? fire_log[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance the reference.
  task automatic step(input int g, input int rd, input logic [31:0] rpc, input int rdy);
    bit          rv;
    bit          fire;
    bit          pop;
    bit          e_req;
    bit          e_valid;
    logic [31:0] fa;
    @(negedge clk);
    reset          = !rst_hold;
    rv             = mem_pend && (mem_cnt == 0);
    imem_gnt       = (g != 0) && !mem_pend;
    imem_rvalid    = rv;
    imem_rdata     = rv ? (mem_stale ? 32'hDEADBEEF : mem_word(mem_addr)) : $urandom;
    redirect_valid = (rd != 0) && !rst_hold;
    redirect_pc    = rpc;
    instr_ready    = (rdy != 0);
    #1;
    fire = 1'b0;
    fa   = m_pc;
    if (instr_valid && instr == 32'hDEADBEEF) saw_dead = 1'b1;
    if (rst_hold) begin
      chk1 ("reset_req",   imem_req,    1'b0);
      chk32("reset_addr",  imem_addr,   RESET_PC);
      chk1 ("reset_valid", instr_valid, 1'b0);
      chk32("reset_instr", instr,       32'h0);
      chk32("reset_pc",    instr_pc,    32'h0);
      q.delete();
      m_pc  = RESET_PC;
      m_out = 1'b0;
      if (mem_pend && !rv) mem_stale = 1'b1;
    end else begin
      e_valid = (q.size() != 0);
      e_req   = !m_out && (q.size() < DEPTH) && !redirect_valid;
      chk1 ("imem_req",    imem_req,    e_req);
      chk32("imem_addr",   imem_addr,   m_pc);
      chk1 ("instr_valid", instr_valid, e_valid);
      if (e_valid) begin
        chk32("instr_pc", instr_pc, q[0]);
        chk32("instr",    instr,    mem_word(q[0]));
      end
      if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (cap_pc && instr_valid) begin
        cap_val = instr_pc;
        cap_pc  = 1'b0;
      end
      fire = e_req && imem_gnt;
      pop  = e_valid && (rdy != 0);
      if (fire) begin
        fire_log.push_back(fa);
        if (first_fire_cyc < 0) first_fire_cyc = cyc;
      end
      if (redirect_valid) begin
        q.delete();
        m_pc = {rpc[31:2], 2'b00};
        if (rv) m_out = 1'b0;
        else if (mem_pend) mem_stale = 1'b1;
      end else begin
        if (pop) void'(q.pop_front());
        if (rv && m_out) begin
          if (!mem_stale) q.push_back(mem_addr);
          m_out = 1'b0;
        end
        if (fire) begin
          m_out = 1'b1;
          m_pc  = m_pc + 32'd4;
        end
      end
    end
    if (rv) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (fire) begin
      mem_pend  = 1'b1;
      mem_addr  = fa;
      mem_stale = 1'b0;
      mem_cnt   = int'($urandom_range(lat_max, lat_min)) - 1;
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_hold = 1'b1;
    repeat (n) step(0, 0, 32'h0, 1);
    rst_hold = 1'b0;
  endtask

  initial begin
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    m_pc = RESET_PC; m_out = 1'b0; mem_pend = 1'b0; mem_cnt = 0;
    mem_addr = '0; mem_stale = 1'b0; saw_dead = 1'b0; cap_pc = 1'b0;
    cap_val = 32'hFFFF_FFFF; first_fire_cyc = -1; first_valid_cyc = -1; redir_cyc = 0;

    // Reset release with grant always and one-cycle memory latency.
    do_reset(2);
    lat_min = 1; lat_max = 1;
    fire_log.delete(); first_fire_cyc = -1; first_valid_cyc = -1;
    repeat (8) step(1, 0, 32'h0, 1);
    chk32("seq_addr0", log_at(0), 32'h0000_0000);
    chk32("seq_addr1", log_at(1), 32'h0000_0004);
    chk32("seq_addr2", log_at(2), 32'h0000_0008);
    chk32("first_valid_latency", 32'(first_valid_cyc - first_fire_cyc), 32'd2);

    // Decode stalled: buffer fills, requests stop, then drain resumes fetch.
    do_reset(1);
    fire_log.delete();
    repeat (10) step(1, 0, 32'h0, 0);
    chk32("full_fetches", 32'(fire_log.size()), 32'd2);
    chk1 ("full_req_low", imem_req, 1'b0);
    chk1 ("full_valid", instr_valid, 1'b1);
    chk32("full_head_pc", instr_pc, 32'h0);
    repeat (6) step(1, 0, 32'h0, 1);
    chk1 ("fetch_resumes", fire_log.size() > 2, 1'b1);

    // Redirect while a fetch is in flight; the stale word must vanish.
    do_reset(1);
    lat_min = 3; lat_max = 3;
    step(1, 0, 32'h0, 1);
    fire_log.delete(); saw_dead = 1'b0;
    step(0, 1, 32'h0000_0100, 1);
    repeat (10) step(1, 0, 32'h0, 1);
    chk1 ("stale_word_hidden", saw_dead, 1'b0);
    chk32("redirect_addr", log_at(0), 32'h0000_0100);

    // Unaligned redirect target from idle: fetch issues the very next cycle.
    lat_min = 1; lat_max = 1;
    repeat (5) step(0, 0, 32'h0, 1);
    fire_log.delete(); first_fire_cyc = -1; redir_cyc = cyc;
    step(0, 1, 32'h0000_0203, 1);
    cap_pc = 1'b1; cap_val = 32'hFFFF_FFFF;
    repeat (6) step(1, 0, 32'h0, 1);
    chk32("aligned_addr", log_at(0), 32'h0000_0200);
    chk32("aligned_instr_pc", cap_val, 32'h0000_0200);
    chk32("redirect_next_cycle", 32'(first_fire_cyc - redir_cyc), 32'd1);

    // Address wrap at the top of the address space.
    fire_log.delete();
    step(0, 1, 32'hFFFF_FFFC, 1);
    repeat (8) step(1, 0, 32'h0, 1);
    chk32("wrap_addr0", log_at(0), 32'hFFFF_FFFC);
    chk32("wrap_addr1", log_at(1), 32'h0000_0000);

    // Reset mid-request, response arriving during reset.
    lat_min = 2; lat_max = 2;
    repeat (5) step(0, 0, 32'h0, 1);
    step(1, 0, 32'h0, 1);
    do_reset(2);
    fire_log.delete();
    repeat (4) step(1, 0, 32'h0, 1);
    chk32("reset_a_first_addr", log_at(0), RESET_PC);

    // Reset mid-request, response arriving after release.
    lat_min = 4; lat_max = 4;
    repeat (6) step(0, 0, 32'h0, 1);
    step(1, 0, 32'h0, 1);
    do_reset(1);
    fire_log.delete();
    repeat (3) step(1, 0, 32'h0, 1);
    step(1, 0, 32'h0, 1);
    chk1 ("reset_b_fifo_empty", instr_valid, 1'b0);
    repeat (6) step(1, 0, 32'h0, 1);
    chk32("reset_b_first_addr", log_at(0), RESET_PC);

    // Randomised traffic.
    lat_min = 1; lat_max = 4; saw_dead = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst_hold = ($urandom_range(299, 0) == 0);
      step(int'($urandom_range(1, 0)), int'($urandom_range(19, 0) == 0),
           $urandom, int'($urandom_range(9, 0) < 7));
    end
    rst_hold = 1'b0;
    chk1("random_stale_hidden", saw_dead, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2: number of prefetch buffer entries; legal values are 2 and 4.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 reset  input  1  asynchronous reset, active-low.
REQ-005 imem_req  output  1  instruction memory fetch request.
REQ-006 imem_addr  output  32  fetch address; bits [1:0] are always 0.
REQ-007 imem_gnt  input  1  memory accepts the request in the cycle where imem_req=1 and imem_gnt=1.
REQ-008 imem_rvalid  input  1  read data valid; arrives at least 1 cycle after the grant.
REQ-009 imem_rdata  input  32  instruction word returned by memory.
REQ-010 redirect_valid  input  1  branch/jump taken, signalled by the datapath.
REQ-011 redirect_pc  input  32  new fetch target.
REQ-012 instr_valid  output  1  an instruction is available to decode.
REQ-013 instr  output  32  instruction word at the FIFO head.
REQ-014 instr_pc  output  32  address of instr.
REQ-015 instr_ready  input  1  decode consumes the head when instr_valid=1 and instr_ready=1.

Function
REQ-016 The block SHALL allow at most one memory request outstanding (granted, no rvalid yet) at any time.
REQ-017 imem_req SHALL be asserted only when state=RUN, no request is outstanding, and FIFO occupancy is less than FIFO_DEPTH.
REQ-018 imem_addr SHALL equal fetch_pc; on grant, fetch_pc SHALL advance by 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-019 A non-stale rvalid SHALL push {fetch address, imem_rdata} into the FIFO.
REQ-020 The FIFO SHALL have registered outputs; an instruction SHALL be visible on instr/instr_valid in the cycle after its rvalid.
REQ-021 A push and a pop in the same cycle SHALL leave occupancy unchanged. Push-when-full SHALL be impossible by construction (REQ-017).
REQ-022 instr/instr_pc SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-023 The FSM SHALL have three states:
- RUN: normal fetch.
- WAIT: request outstanding.
- DROP: outstanding response is stale.
REQ-024 FSM transitions SHALL be:
- RUN -> WAIT on grant.
- WAIT -> RUN on rvalid.
- WAIT -> DROP on redirect without rvalid.
- DROP -> RUN on rvalid, with the data discarded.
REQ-025 On redirect_valid, in the same edge the block SHALL:
- flush the FIFO;
- set fetch_pc to {redirect_pc[31:2], 2'b00};
- assert no imem_req in the redirect cycle.
REQ-026 Redirect simultaneous with any of the following SHALL be resolved as follows:
- with rvalid: data discarded, next state RUN;
- with grant: that response marked stale, next state DROP;
- with pop: flush wins;
- in DROP: stay in DROP.
REQ-027 A redirect in RUN with nothing outstanding SHALL issue the first new-target request in the next cycle.

Reset
REQ-028 While reset=0, the block SHALL hold:
- state=RUN;
- fetch_pc=RESET_PC;
- FIFO empty, instr_valid=0, instr=0, instr_pc=0;
- imem_req=0.
REQ-029 imem_req=1 with imem_addr=RESET_PC SHALL appear in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-request SHALL abandon the request; any response arriving after reset SHALL be ignored.

Structure
REQ-031 Shared package rv32_pkg SHALL hold XLEN=32, INSTR_BYTES=4 and the fetch_state_t enum {RUN, WAIT, DROP}.
REQ-032 The FIFO SHALL be a single sub-module, fetch_fifo (parameterised depth, payload 64 bits, flush input); all other logic SHALL remain flat in fetch_unit.

Verification
REQ-033 Reset release with gnt=1 and rvalid 1 cycle later -> addresses 0x0, 0x4, 0x8 fetched in order; instr_valid first rises 2 cycles after the first grant.
REQ-034 instr_ready=0 with FIFO_DEPTH=2 -> exactly 2 entries buffered, then imem_req=0; ready=1 -> one pop per cycle, fetching resumes.
REQ-035 Redirect to 0x100 while WAIT, then stale rvalid with 0xDEADBEEF -> 0xDEADBEEF never appears on instr; next imem_addr=0x100.
REQ-036 Redirect to 0x203 -> imem_addr=0x200, and instr_pc=0x200 for the returned word.
REQ-037 fetch_pc=0xFFFF_FFFC granted -> next imem_addr=0x0000_0000.
REQ-038 reset=0 asserted while WAIT, then rvalid during reset and after release -> FIFO empty; first post-reset fetch at RESET_PC.
